// File: rtl/rv32im_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit.
// Op codes, FSM encoding and divider iteration count.
package rv32im_muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'h08;
  localparam logic [4:0] OP_MULH   = 5'h09;
  localparam logic [4:0] OP_MULHSU = 5'h0A;
  localparam logic [4:0] OP_MULHU  = 5'h0B;
  localparam logic [4:0] OP_DIV    = 5'h0C;
  localparam logic [4:0] OP_DIVU   = 5'h0D;
  localparam logic [4:0] OP_REM    = 5'h0E;
  localparam logic [4:0] OP_REMU   = 5'h0F;

  localparam int DIV_ITERATIONS = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_radix2_divider.sv
// Unsigned 32-bit radix-2 restoring divider.
// The first iteration is folded into the start edge.
module muldiv_radix2_divider
  import rv32im_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam logic [5:0] LAST = 6'(DIV_ITERATIONS - 1);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] rem_in, quo_in, dvs_in;
  logic [32:0] shifted, diff;
  logic [31:0] rem_nx, quo_nx;

  always_comb begin
    rem_in  = start_i ? 32'd0 : rem_q;
    quo_in  = start_i ? dividend_i : quo_q;
    dvs_in  = start_i ? divisor_i : dvs_q;
    shifted = {rem_in, quo_in[31]};
    diff    = shifted - {1'b0, dvs_in};
    // bit 32 set means the trial subtraction underflowed
    if (!diff[32]) begin
      rem_nx = diff[31:0];
      quo_nx = {quo_in[30:0], 1'b1};
    end else begin
      rem_nx = shifted[31:0];
      quo_nx = {quo_in[30:0], 1'b0};
    end

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d  = rem_nx;
      quo_d  = quo_nx;
      dvs_d  = divisor_i;
      cnt_d  = 6'd1;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M multiply/divide unit.
// Stalls the pipeline while busy, pulses VALID with the result.
module ex_muldiv_unit
  import rv32im_muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [4:0]      EX_ALU_SELECT,
  input  logic [XLEN-1:0] EX_OPERAND_A,
  input  logic [XLEN-1:0] EX_OPERAND_B,
  output logic [XLEN-1:0] MULDIV_RESULT,
  output logic            MULDIV_BUSY,
  output logic            MULDIV_VALID
);

  md_state_e   state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic [3:0]  mcnt_q, mcnt_d;

  logic        is_mop, is_div, is_rem, sdiv;
  logic        a_neg, b_neg, dbz, ovf;
  logic [31:0] a_abs, b_abs, spec_res;
  logic        a_sgn, b_sgn;
  logic signed [63:0] prod;
  logic [31:0] mul_res, div_res;
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem;

  muldiv_radix2_divider u_div (
    .clk        (CLK),
    .rst        (RESET),
    .start_i    (div_start),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  always_comb begin
    is_mop = (EX_ALU_SELECT[4:3] == 2'b01);
    is_div = EX_ALU_SELECT[2];
    is_rem = EX_ALU_SELECT[1];
    sdiv   = !EX_ALU_SELECT[0];
    a_neg  = sdiv & EX_OPERAND_A[31];
    b_neg  = sdiv & EX_OPERAND_B[31];
    a_abs  = a_neg ? -EX_OPERAND_A : EX_OPERAND_A;
    b_abs  = b_neg ? -EX_OPERAND_B : EX_OPERAND_B;
    dbz    = (EX_OPERAND_B == 32'd0);
    ovf    = sdiv && (EX_OPERAND_A == 32'h8000_0000)
                  && (EX_OPERAND_B == 32'hFFFF_FFFF);
    if (dbz)
      spec_res = is_rem ? EX_OPERAND_A : 32'hFFFF_FFFF;
    else
      spec_res = is_rem ? 32'd0 : 32'h8000_0000;

    a_sgn   = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    b_sgn   = (op_q == OP_MULH);
    prod    = $signed({a_sgn & a_q[31], a_q})
            * $signed({b_sgn & b_q[31], b_q});
    mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];

    if (op_q[1])
      div_res = r_neg_q ? -div_rem : div_rem;
    else
      div_res = q_neg_q ? -div_quo : div_quo;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    mcnt_d    = mcnt_q;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: if (is_mop) begin
        op_d = EX_ALU_SELECT;
        a_d  = EX_OPERAND_A;
        b_d  = EX_OPERAND_B;
        if (!is_div) begin
          state_d = ST_MUL_BUSY;
          mcnt_d  = 4'd0;
        end else if (dbz || ovf) begin
          state_d  = ST_DONE;
          result_d = spec_res;
          valid_d  = 1'b1;
        end else begin
          state_d   = ST_DIV_BUSY;
          div_start = 1'b1;
          q_neg_d   = a_neg ^ b_neg;
          r_neg_d   = a_neg;
        end
      end
      ST_MUL_BUSY: begin
        if (mcnt_q == 4'(MUL_LATENCY - 1)) begin
          state_d  = ST_DONE;
          result_d = mul_res;
          valid_d  = 1'b1;
        end else begin
          mcnt_d = mcnt_q + 4'd1;
        end
      end
      ST_DIV_BUSY: if (div_done) begin
        state_d  = ST_DONE;
        result_d = div_res;
        valid_d  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign MULDIV_BUSY = !RESET && (((state_q == ST_IDLE) && is_mop)
                     || (state_q == ST_MUL_BUSY)
                     || (state_q == ST_DIV_BUSY));
  assign MULDIV_VALID  = valid_q;
  assign MULDIV_RESULT = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit.
// Latency, result and stall behaviour per op.
module tb_ex_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  sel;
  logic [31:0] opa, opb, res;
  logic        busy, valid;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_valid_cyc = 0;

  ex_muldiv_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .EX_ALU_SELECT(sel),
    .EX_OPERAND_A (opa),
    .EX_OPERAND_B (opb),
    .MULDIV_RESULT(res),
    .MULDIV_BUSY  (busy),
    .MULDIV_VALID (valid)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK)
    if (valid) begin
      n_valid <= n_valid + 1;
      last_valid_cyc <= cyc;
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res,
                        input bit mut);
    int lat;
    bit busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    sel = op;
    opa = a;
    opb = b;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (valid) begin
        lat = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (mut && c == 5) opa = 32'h1234_5678;
      @(posedge CLK);
      #1;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, res, exp_res);
    chk({tag, ".busy_done"}, {31'b0, busy}, 32'd0);
    chk({tag, ".busy_stall"}, {31'b0, busy_ok}, 32'd1);
    @(posedge CLK);
    #1;
    sel = 5'h00;
    opa = 32'd0;
    opb = 32'd0;
  endtask

  initial begin
    int v0, s0;
    RESET = 1'b1;
    sel = 5'h00;
    opa = 32'd0;
    opb = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst.res", res, 32'd0);
    chk("rst.valid", {31'b0, valid}, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd0);

    // non-M op must leave the unit idle
    @(posedge CLK);
    #1;
    sel = 5'h02;
    opa = 32'd5;
    opb = 32'd6;
    v0 = n_valid;
    @(negedge CLK);
    chk("alu.busy", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge CLK);
    chk("alu.valid_cnt", n_valid - v0, 32'd0);
    @(posedge CLK);
    #1;

    run_op("mul", 5'h08, 32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFEB, 0);
    run_op("mulhu", 5'h0B, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,
           32'hFFFF_FFFE, 0);
    run_op("mulh", 5'h09, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'd0, 0);
    run_op("mulhsu", 5'h0A, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,
           32'hFFFF_FFFF, 0);
    run_op("div", 5'h0C, 32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFA, 0);
    run_op("rem", 5'h0E, 32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFE, 0);
    run_op("divu", 5'h0D, 32'd100, 32'd7, 33, 32'd14, 0);
    run_op("remu", 5'h0F, 32'd100, 32'd7, 33, 32'd2, 0);
    run_op("divu0", 5'h0D, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, 0);
    run_op("remu0", 5'h0F, 32'd100, 32'd0, 1, 32'd100, 0);
    run_op("rem0", 5'h0E, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 0);
    run_op("divovf", 5'h0C, 32'h8000_0000, 32'hFFFF_FFFF, 1,
           32'h8000_0000, 0);
    run_op("removf", 5'h0E, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 0);
    run_op("divmut", 5'h0C, 32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFA, 1);

    // back-to-back MUL then DIV
    v0 = n_valid;
    s0 = cyc;
    run_op("b2b.mul", 5'h08, 32'd6, 32'd9, 2, 32'd54, 0);
    run_op("b2b.div", 5'h0C, 32'd1000, 32'hFFFF_FFF9, 33,
           32'hFFFF_FF72, 0);
    chk("b2b.pulses", n_valid - v0, 32'd2);
    chk("b2b.div_cycle", last_valid_cyc - s0, 32'd36);

    // reset in the middle of a divide
    sel = 5'h0C;
    opa = 32'hFFFF_FFEC;
    opb = 32'd3;
    repeat (10) begin
      @(posedge CLK);
      #1;
    end
    RESET = 1'b1;
    @(negedge CLK);
    chk("rstmid.busy_in_rst", {31'b0, busy}, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    sel = 5'h00;
    @(negedge CLK);
    chk("rstmid.busy", {31'b0, busy}, 32'd0);
    chk("rstmid.valid", {31'b0, valid}, 32'd0);
    chk("rstmid.res", res, 32'd0);
    v0 = n_valid;
    repeat (40) @(negedge CLK);
    chk("rstmid.no_pulse", n_valid - v0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit for the RV32M instructions, located in the EX stage directly after the ID/EX pipeline register.
- Consumes that register's ALU select and the two forwarded operand values.
- Drives a stall request to the hazard unit while it works, then presents a 32-bit result for EX/MEM to capture.
- The single-cycle ALU handles every non-M operation; this block stays idle for those.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MUL_LATENCY, 1, registered multiply cycles after the start cycle.

Ports:
- CLK  input  1  clock
- RESET  input  1  reset
- EX_ALU_SELECT  input  5  operation code from ID/EX
- EX_OPERAND_A  input  32  rs1 value, after forwarding
- EX_OPERAND_B  input  32  rs2 value, after forwarding
- MULDIV_RESULT  output  32  result; valid only while MULDIV_VALID=1
- MULDIV_BUSY  output  1  stall request; freezes PC, IF/ID and ID/EX
- MULDIV_VALID  output  1  one-cycle completion pulse

Behaviour:
- One clock, CLK. RESET is synchronous and active-high.
- Reset:
  - State returns to IDLE; MULDIV_RESULT=0, MULDIV_VALID=0.
  - MULDIV_BUSY is forced to 0 while RESET=1.
  - Reset mid-operation abandons the operation immediately, with no VALID pulse.
- M-op codes:
  - MUL=5'h08, MULH=5'h09, MULHSU=5'h0A, MULHU=5'h0B.
  - DIV=5'h0C, DIVU=5'h0D, REM=5'h0E, REMU=5'h0F.
  - is_mop = (EX_ALU_SELECT in 5'h08..5'h0F).
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- IDLE:
  - If is_mop, latch the op and both operands on the clock edge.
  - MUL ops go to MUL_BUSY; DIV/REM ops go to DIV_BUSY, or straight to DONE for the special cases below.
  - Operands are sampled only here. Later changes on the operand inputs, e.g. forwarding updates during the stall, are ignored.
- MULDIV_BUSY is combinational: (state==IDLE && is_mop) || state==MUL_BUSY || state==DIV_BUSY. It is 0 in DONE.
- MUL_BUSY:
  - Computes the 64-bit product, with operands sign- or zero-extended per op (MULHSU: A signed, B unsigned).
  - After MUL_LATENCY cycles, go to DONE.
  - MUL selects product[31:0]; the other three select product[63:32].
- DIV_BUSY:
  - Radix-2 restoring division on |A| and |B| (absolute values for signed ops), exactly 32 iteration cycles, then DONE.
  - Sign fix-up on exit: quotient negated if sign(A)!=sign(B); remainder takes the sign of A.
- Special cases, decided in IDLE (IDLE to DONE directly, latency 1):
  - B==0: quotient = 32'hFFFFFFFF, remainder = A.
  - Signed overflow (A=32'h80000000, B=32'hFFFFFFFF): quotient = 32'h80000000, remainder = 0.
- DONE:
  - MULDIV_VALID=1 and MULDIV_RESULT is driven for exactly one cycle.
  - BUSY=0 in this cycle, so the pipeline advances on this edge.
  - Next state is always IDLE; the same instruction is never re-launched.
  - A back-to-back M-op starts in the following IDLE cycle.
- Outside DONE: MULDIV_VALID=0 and MULDIV_RESULT holds its last value.
- Cycle counts, op first seen in EX = cycle 0:
  - MUL: VALID at cycle 2.
  - Normal DIV/REM: VALID at cycle 33.
  - Special-case DIV/REM: VALID at cycle 1.

Decomposition:
- Package rv32im_muldiv_pkg holds:
  - the eight op-code localparams;
  - the state encoding (2 bits);
  - the DIV_ITERATIONS=32 constant.
- One sub-module, muldiv_radix2_divider:
  - unsigned 32-bit iterative core with start/done handshake;
  - outputs quotient and remainder.
- Sign handling and the special-case logic stay in the top module.

Test Plan:
- MUL: A=7, B=-3 (32'hFFFFFFFD).
  - BUSY=1 for cycles 0–1.
  - Cycle 2: VALID=1, RESULT=32'hFFFFFFEB.
- MULHU: A=B=32'hFFFFFFFF -> cycle 2 RESULT=32'hFFFFFFFE.
- MULH: same operands -> RESULT=0.
- DIV: A=-20, B=3.
  - BUSY=1 for cycles 0–32.
  - Cycle 33: VALID=1, RESULT=-6 (32'hFFFFFFFA).
- REM: A=-20, B=3 -> RESULT=32'hFFFFFFFE.
- Divide by zero:
  - DIVU A=100, B=0 -> cycle 1 RESULT=32'hFFFFFFFF.
  - REMU A=100, B=0 -> RESULT=100.
- Overflow: DIV A=32'h80000000, B=-1 -> cycle 1 RESULT=32'h80000000.
- Robustness:
  - Change EX_OPERAND_A during DIV_BUSY -> result unchanged.
  - Assert RESET at cycle 10 of a DIV -> next cycle BUSY=0, VALID=0, RESULT=0, and no VALID pulse afterwards.
  - Back-to-back MUL then DIV -> two separate VALID pulses, at cycles 2 and 36.
